// File: rtl/uart_regfile_fifo.sv
// UART register block: bus register slave, TX/RX byte FIFOs, baud divisor and W1C interrupts.
// Optional TX->RX internal loopback (CFG[5]) is built only when UART_LOOPBACK_EN is defined.
module uart_regfile_fifo #(
  parameter int unsigned       ADDR_W     = 12,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 8,
  parameter int unsigned       BAUD_W     = 16,
  parameter logic [BAUD_W-1:0] BAUD_RST   = BAUD_W'(868)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata,
  output logic              wack,
  output logic              rack,
  output logic              waddrerr,
  output logic              raddrerr,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_parity_err,
  output logic [1:0]        data_bit_num,
  output logic              stop_bit_num,
  output logic              parity_en,
  output logic              parity_type,
  output logic [BAUD_W-1:0] baud_div,
  output logic              irq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = 5;
`ifdef UART_LOOPBACK_EN
  localparam int unsigned CFG_W = 6;
`else
  localparam int unsigned CFG_W = 5;
`endif

  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_CFG    = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_BAUD   = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] A_ISTAT  = ADDR_W'(32'h14);
  localparam logic [ADDR_W-1:0] A_IEN    = ADDR_W'(32'h18);

  logic [7:0]        tx_mem [FIFO_DEPTH];
  logic [7:0]        rx_mem [FIFO_DEPTH];
  logic [PW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]     tx_cnt, rx_cnt, tx_cnt_nxt, rx_cnt_nxt;
  logic [CFG_W-1:0]  cfg;
  logic [BAUD_W-1:0] baud;
  logic [IW-1:0]     int_stat, int_en, int_set, int_clr, int_stat_nxt;

  logic              tx_full, rx_full, tx_push, tx_pop, tx_ovf, rx_push, rx_pop, rx_ovr;
  logic              lb_on, lb_move, rx_in_valid;
  logic [7:0]        rx_in_data;
  logic              w_txdata, w_cfg, w_baud, w_istat, w_ien, w_err;
  logic              r_rxdata, r_err;
  logic [DATA_W-1:0] rd_val;
  logic [31:0]       status;
  logic              unused_wdata;

  assign unused_wdata = ^wdata;

  assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
  assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
  assign tx_data  = tx_mem[tx_rp];
  assign tx_valid = (tx_cnt != '0) && !lb_on;

  assign data_bit_num = cfg[1:0];
  assign stop_bit_num = cfg[2];
  assign parity_en    = cfg[3];
  assign parity_type  = cfg[4];
  assign baud_div     = baud;
  assign irq          = |(int_stat & int_en);

`ifdef UART_LOOPBACK_EN
  // Loopback moves the TX head straight into the RX tail; never overruns
  assign lb_on       = cfg[5];
  assign lb_move     = lb_on && (tx_cnt != '0) && !rx_full;
  assign rx_in_valid = lb_on ? lb_move : rx_valid;
  assign rx_in_data  = lb_on ? tx_data : rx_data;
`else
  assign lb_on       = 1'b0;
  assign lb_move     = 1'b0;
  assign rx_in_valid = rx_valid;
  assign rx_in_data  = rx_data;
`endif

  // Write address decode
  always_comb begin
    w_txdata = 1'b0;
    w_cfg    = 1'b0;
    w_baud   = 1'b0;
    w_istat  = 1'b0;
    w_ien    = 1'b0;
    w_err    = 1'b0;
    if (wr_en) begin
      case (waddr)
        A_TXDATA: w_txdata = 1'b1;
        A_CFG:    w_cfg    = 1'b1;
        A_BAUD:   w_baud   = 1'b1;
        A_ISTAT:  w_istat  = 1'b1;
        A_IEN:    w_ien    = 1'b1;
        default:  w_err    = 1'b1;
      endcase
    end
  end

  // Read mux; an RXDATA read of an empty FIFO returns 0 without popping
  always_comb begin
    status   = {8'd0, 8'(rx_cnt), 8'(tx_cnt), 4'd0,
                rx_full, (rx_cnt == '0), tx_full, (tx_cnt == '0)};
    rd_val   = '0;
    r_rxdata = 1'b0;
    r_err    = 1'b0;
    case (raddr)
      A_TXDATA: rd_val = DATA_W'(tx_cnt);
      A_RXDATA: begin
        r_rxdata = rd_en;
        rd_val   = (rx_cnt != '0) ? DATA_W'(rx_mem[rx_rp]) : '0;
      end
      A_CFG:    rd_val = DATA_W'(cfg);
      A_BAUD:   rd_val = DATA_W'(baud);
      A_STATUS: rd_val = DATA_W'(status);
      A_ISTAT:  rd_val = DATA_W'(int_stat);
      A_IEN:    rd_val = DATA_W'(int_en);
      default:  r_err  = 1'b1;
    endcase
  end

  // FIFO push/pop; a pop in the same cycle frees the slot for a push into a full FIFO
  always_comb begin
    tx_pop     = (tx_valid && tx_ready) || lb_move;
    tx_push    = w_txdata && (!tx_full || tx_pop);
    tx_ovf     = w_txdata && !tx_push;
    rx_pop     = r_rxdata && (rx_cnt != '0);
    rx_push    = rx_in_valid && (!rx_full || rx_pop);
    rx_ovr     = rx_in_valid && !rx_push;
    tx_cnt_nxt = tx_cnt + CW'(tx_push) - CW'(tx_pop);
    rx_cnt_nxt = rx_cnt + CW'(rx_push) - CW'(rx_pop);
  end

  // Set events win over a same-cycle W1C
  always_comb begin
    int_set      = {tx_ovf, rx_parity_err, rx_ovr, (rx_cnt_nxt != '0),
                    (tx_cnt == CW'(1)) && tx_pop && !tx_push};
    int_clr      = w_istat ? wdata[IW-1:0] : '0;
    int_stat_nxt = (int_stat & ~int_clr) | int_set;
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      cfg      <= '0;
      baud     <= BAUD_RST;
      int_stat <= '0;
      int_en   <= '0;
      rdata    <= '0;
      wack     <= 1'b0;
      waddrerr <= 1'b0;
      rack     <= 1'b0;
      raddrerr <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
      tx_cnt   <= tx_cnt_nxt;
      rx_cnt   <= rx_cnt_nxt;
      if (w_cfg)  cfg    <= wdata[CFG_W-1:0];
      if (w_baud) baud   <= wdata[BAUD_W-1:0];
      if (w_ien)  int_en <= wdata[IW-1:0];
      int_stat <= int_stat_nxt;
      wack     <= wr_en;
      waddrerr <= w_err;
      rack     <= rd_en;
      raddrerr <= rd_en && r_err;
      if (rd_en) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_uart_regfile_fifo.sv
// Directed self-checking bench for uart_regfile_fifo (default parameters).
module tb_uart_regfile_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] waddr, raddr;
  logic [31:0] wdata, rdata;
  logic        wr_en, rd_en, wack, rack, waddrerr, raddrerr;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_parity_err;
  logic [1:0]  data_bit_num;
  logic        stop_bit_num, parity_en, parity_type, irq;
  logic [15:0] baud_div;

  int checks = 0;
  int errors = 0;

  uart_regfile_fifo dut (
    .clk(clk), .rst(rst), .waddr(waddr), .wdata(wdata), .wr_en(wr_en),
    .raddr(raddr), .rd_en(rd_en), .rdata(rdata), .wack(wack), .rack(rack),
    .waddrerr(waddrerr), .raddrerr(raddrerr), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err), .data_bit_num(data_bit_num),
    .stop_bit_num(stop_bit_num), .parity_en(parity_en), .parity_type(parity_type),
    .baud_div(baud_div), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    waddr = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    raddr = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rv;
    logic [7:0]  exp_b [3];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;

    rst = 1'b1; waddr = '0; raddr = '0; wdata = '0; wr_en = 1'b0; rd_en = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_parity_err = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset values
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_acks", {28'd0, wack, rack, waddrerr, raddrerr}, 32'h0);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_baud_div", 32'(baud_div), 32'd868);
    bus_read(12'h00C, rv);
    check_eq("rst_baud_rd", rv, 32'd868);
    check_eq("rst_baud_rack", {30'd0, rack, raddrerr}, 32'h2);

    // TX ordering and tx_empty event
    for (int i = 0; i < 3; i++) bus_write(12'h000, 32'(exp_b[i]));
    check_eq("tx_wack", {30'd0, wack, waddrerr}, 32'h2);
    bus_read(12'h010, rv);
    check_eq("tx3_status", rv, 32'h0000_0304);
    bus_read(12'h000, rv);
    check_eq("tx3_level", rv, 32'd3);
    check_eq("tx3_head", 32'(tx_data), 32'h11);
    check_eq("tx3_valid", 32'(tx_valid), 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("tx_pop_byte", 32'(tx_data), 32'(exp_b[i]));
      tick();
    end
    tx_ready = 1'b0;
    check_eq("tx_drained_valid", 32'(tx_valid), 32'h0);
    bus_read(12'h014, rv);
    check_eq("istat_tx_empty", rv, 32'h01);
    bus_write(12'h014, 32'h01);
    bus_read(12'h014, rv);
    check_eq("istat_w1c", rv, 32'h00);

    // TX overflow and irq masking
    for (int i = 0; i < 9; i++) bus_write(12'h000, 32'h40 + 32'(i));
    bus_read(12'h010, rv);
    check_eq("tx_full_status", rv, 32'h0000_0806);
    bus_read(12'h014, rv);
    check_eq("istat_tx_ovf", rv, 32'h10);
    check_eq("irq_masked", 32'(irq), 32'h0);
    bus_write(12'h018, 32'h10);
    check_eq("irq_enabled", 32'(irq), 32'h1);
    bus_write(12'h014, 32'h10);
    check_eq("irq_cleared", 32'(irq), 32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("tx_full_order", 32'(tx_data), 32'h40 + 32'(i));
      tick();
    end
    tx_ready = 1'b0;
    bus_read(12'h014, rv);
    check_eq("istat_tx_empty2", rv, 32'h01);
    bus_write(12'h014, 32'h1F);
    bus_write(12'h018, 32'h00);

    // RX overrun and ordered drain
    for (int i = 0; i < 9; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'h80 + 8'(i);
      tick();
    end
    rx_valid = 1'b0;
    bus_read(12'h010, rv);
    check_eq("rx_full_status", rv, 32'h0008_0009);
    bus_read(12'h014, rv);
    check_eq("istat_rx_ovr", rv, 32'h06);
    for (int i = 0; i < 9; i++) begin
      bus_read(12'h004, rv);
      check_eq("rx_pop_byte", rv, (i < 8) ? 32'h80 + 32'(i) : 32'h0);
      check_eq("rx_pop_ack", {30'd0, rack, raddrerr}, 32'h2);
    end
    bus_write(12'h014, 32'h06);
    bus_read(12'h014, rv);
    check_eq("istat_rx_clr", rv, 32'h00);

    // rx push coincident with W1C of rx_avail
    rx_valid = 1'b1; rx_data = 8'h5A;
    waddr = 12'h014; wdata = 32'h02; wr_en = 1'b1;
    tick();
    rx_valid = 1'b0; wr_en = 1'b0;
    bus_read(12'h014, rv);
    check_eq("istat_avail_wins", rv, 32'h02);
    bus_read(12'h004, rv);
    check_eq("rx_coinc_byte", rv, 32'h5A);
    rx_parity_err = 1'b1;
    tick();
    rx_parity_err = 1'b0;
    bus_read(12'h014, rv);
    check_eq("istat_parity", rv, 32'h0A);
    bus_write(12'h014, 32'h0A);

    // Simultaneous errored write and read
    bus_read(12'h00C, rv);
    waddr = 12'h010; wdata = 32'hFFFF_FFFF; wr_en = 1'b1;
    raddr = 12'h020; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("dual_err_flags", {28'd0, wack, waddrerr, rack, raddrerr}, 32'hF);
    check_eq("dual_err_rdata", rdata, 32'h0);
    bus_read(12'h010, rv);
    check_eq("status_unchanged", rv, 32'h0000_0005);
    bus_write(12'h004, 32'h12);
    check_eq("wr_rxdata_err", {30'd0, wack, waddrerr}, 32'h3);

    // CFG and BAUD
    bus_write(12'h008, 32'hFFFF_FFFF);
    bus_read(12'h008, rv);
`ifdef UART_LOOPBACK_EN
    check_eq("cfg_all_ones", rv, 32'h3F);
`else
    check_eq("cfg_all_ones", rv, 32'h1F);
`endif
    bus_write(12'h008, 32'h0A);
    check_eq("cfg_outputs", {27'd0, data_bit_num, stop_bit_num, parity_en, parity_type},
             32'b10_0_1_0);
    bus_write(12'h00C, 32'hABCD_1234);
    check_eq("baud_div_out", 32'(baud_div), 32'h1234);
    bus_read(12'h00C, rv);
    check_eq("baud_rd", rv, 32'h1234);

`ifdef UART_LOOPBACK_EN
    bus_write(12'h008, 32'h20);
    tx_ready = 1'b1;
    bus_write(12'h000, 32'hA5);
    check_eq("lb_tx_valid0", 32'(tx_valid), 32'h0);
    tick();
    check_eq("lb_tx_valid1", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    bus_read(12'h004, rv);
    check_eq("lb_rx_byte", rv, 32'hA5);
    bus_read(12'h014, rv);
    check_eq("lb_no_overrun", rv & 32'h04, 32'h0);
    bus_write(12'h008, 32'h00);
`endif

    // Reset during an access aborts it and flushes the FIFOs
    bus_write(12'h000, 32'h77);
    bus_write(12'h000, 32'h78);
    rst = 1'b1;
    waddr = 12'h000; wdata = 32'h99; wr_en = 1'b1;
    raddr = 12'h00C; rd_en = 1'b1;
    tick();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check_eq("rst_mid_acks", {30'd0, wack, rack}, 32'h0);
    check_eq("rst_mid_txv", 32'(tx_valid), 32'h0);
    check_eq("rst_mid_baud", 32'(baud_div), 32'd868);
    bus_read(12'h010, rv);
    check_eq("rst_mid_status", rv, 32'h0000_0005);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
